// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for a 5-stage core: drives PC and latch enables/flushes from
// cache handshakes, load-use hazards, EX redirects and the WB halt flag.
module pipeline_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t state;
    logic   ihit_pend;

    logic dreq;
    logic ihit_ok;
    logic running;
    logic advance;
    logic load_use;

    // Gating on rst drops every enable the moment reset rises, even mid-stall.
    assign running  = (state == RUN) && !rst;
    assign dreq     = mem_dren | mem_dwen;
    assign ihit_ok  = ihit | ihit_pend;
    assign advance  = running & ihit_ok & (!dreq | dhit);
    assign load_use = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    assign halt     = (state == HALTED);

    always_comb begin
        pc_en      = advance;
        ifid_en    = advance;
        idex_en    = advance;
        exmem_en   = advance;
        memwb_en   = advance;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (advance && ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (advance && load_use) begin
            // Hold PC and IF/ID so the dependent instruction re-issues behind a bubble.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ihit_pend <= 1'b0;
            stall_cnt <= '0;
        end else if (state == RUN) begin
            if (!advance && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            // An early ihit is remembered until the dmem access lets the pipe move.
            if (advance || wb_halt)
                ihit_pend <= 1'b0;
            else if (ihit && dreq && !dhit)
                ihit_pend <= 1'b1;
            if (wb_halt)
                state <= HALTED;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: table of combinational decode vectors plus timed
// sequences for dmem stalls, halt, counter saturation and async reset.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ihit = 1'b0, dhit = 1'b0, mem_dren = 1'b0, mem_dwen = 1'b0;
    logic       idex_memread = 1'b0, ex_redirect = 1'b0, wb_halt = 1'b0;
    logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
    logic [15:0] stall_cnt;
    logic        pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2, ifid_flush2, idex_flush2, halt2;
    logic [1:0]  stall_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren),
        .mem_dwen(mem_dwen), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    pipeline_ctrl #(.REG_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren),
        .mem_dwen(mem_dwen), .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en2), .ifid_en(ifid_en2), .idex_en(idex_en2), .exmem_en(exmem_en2),
        .memwb_en(memwb_en2), .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
        .halt(halt2), .stall_cnt(stall_cnt2)
    );

    // Output bundle order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] got1();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    endfunction

    function automatic logic [6:0] got2();
        return {pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2, ifid_flush2, idex_flush2};
    endfunction

    typedef struct {
        string      name;
        logic       ihit, dhit, dren, dwen, memread, redir;
        logic [4:0] irt, rs, rt;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string n, input logic ih, input logic dh, input logic dr,
                          input logic dw, input logic mr, input logic [4:0] irt,
                          input logic [4:0] rs, input logic [4:0] rt, input logic rd,
                          input logic [6:0] e);
        vec_t v;
        v.name = n; v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.memread = mr;
        v.irt = irt; v.rs = rs; v.rt = rt; v.redir = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", n, act, exp);
        end
    endtask

    task automatic neutral();
        ihit = 1'b0; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
        idex_memread = 1'b0; ex_redirect = 1'b0; wb_halt = 1'b0;
        idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; mem_dren = v.dren; mem_dwen = v.dwen;
        idex_memread = v.memread; idex_rt = v.irt; ifid_rs = v.rs; ifid_rt = v.rt;
        ex_redirect = v.redir; wb_halt = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        neutral();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        addVec("run_plain",     1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 7'b1111100);
        addVec("no_ihit",       0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 7'b0000000);
        addVec("load_miss",     1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 7'b0000000);
        addVec("load_hit",      1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 7'b1111100);
        addVec("store_miss",    1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 7'b0000000);
        addVec("lu_rs",         1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 7'b0011101);
        addVec("lu_rt",         1, 0, 0, 0, 1, 5'd7, 5'd2, 5'd7, 0, 7'b0011101);
        addVec("lu_reg0",       1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 7'b1111100);
        addVec("lu_nomatch",    1, 0, 0, 0, 1, 5'd5, 5'd6, 5'd4, 0, 7'b1111100);
        addVec("match_noload",  1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, 7'b1111100);
        addVec("redir_over_lu", 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 7'b1111111);
        addVec("redir_plain",   1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 7'b1111111);
        addVec("redir_stalled", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 7'b0000000);
        addVec("lu_stalled",    0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 7'b0000000);
        addVec("lu_wait_dhit",  1, 1, 0, 1, 1, 5'd3, 5'd3, 5'd0, 0, 7'b0011101);

        #1;
        checkOutput("reset_enables", {25'd0, got1()}, 32'd0);
        checkOutput("reset_halt", {31'd0, halt}, 32'd0);
        step();
        doReset();
        checkOutput("reset_cnt", {16'd0, stall_cnt}, 32'd0);

        // Each vector sits in its own clock period, neutral inputs before the next edge.
        foreach (vecs[i]) begin
            step();
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i].name, {25'd0, got1()}, {25'd0, vecs[i].exp});
            checkOutput({vecs[i].name, "_w2"}, {25'd0, got2()}, {25'd0, vecs[i].exp});
            neutral();
        end

        // Free-running fetch with no hazards.
        step();
        doReset();
        ihit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("t1_enables", {25'd0, got1()}, {25'd0, 7'b1111100});
            checkOutput("t1_cnt", {16'd0, stall_cnt}, 32'd0);
            step();
        end

        // Early ihit during a slow load is remembered until dhit.
        doReset();
        mem_dren = 1'b1; ihit = 1'b1;
        #1;
        checkOutput("t2_c0_en", {25'd0, got1()}, 32'd0);
        step();
        ihit = 1'b0;
        #1;
        checkOutput("t2_c1_en", {25'd0, got1()}, 32'd0);
        checkOutput("t2_c1_cnt", {16'd0, stall_cnt}, 32'd1);
        step();
        #1;
        checkOutput("t2_c2_en", {25'd0, got1()}, 32'd0);
        checkOutput("t2_c2_cnt", {16'd0, stall_cnt}, 32'd2);
        step();
        dhit = 1'b1;
        #1;
        checkOutput("t2_c3_en", {25'd0, got1()}, {25'd0, 7'b1111100});
        checkOutput("t2_c3_cnt", {16'd0, stall_cnt}, 32'd3);
        step();
        mem_dren = 1'b0; dhit = 1'b0;
        #1;
        checkOutput("t2_pend_clr", {25'd0, got1()}, 32'd0);
        checkOutput("t2_c4_cnt", {16'd0, stall_cnt}, 32'd3);

        // Halt while stalled: count includes the halting edge, then freezes.
        step();
        doReset();
        step();
        step();
        wb_halt = 1'b1;
        #1;
        checkOutput("t5_pre_halt", {31'd0, halt}, 32'd0);
        step();
        wb_halt = 1'b0; ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t5_halt", {31'd0, halt}, 32'd1);
            checkOutput("t5_en", {25'd0, got1()}, 32'd0);
            checkOutput("t5_cnt", {16'd0, stall_cnt}, 32'd3);
            step();
        end
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_halt", {31'd0, halt}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("t5_resume", {25'd0, got1()}, {25'd0, 7'b1111100});

        // Halt and redirect together: this cycle is a redirect, halted afterwards.
        step();
        doReset();
        ihit = 1'b1; ex_redirect = 1'b1; wb_halt = 1'b1;
        #1;
        checkOutput("hr_redirect", {25'd0, got1()}, {25'd0, 7'b1111111});
        checkOutput("hr_pre_halt", {31'd0, halt}, 32'd0);
        step();
        ex_redirect = 1'b0; wb_halt = 1'b0;
        #1;
        checkOutput("hr_halt", {31'd0, halt}, 32'd1);
        checkOutput("hr_en", {25'd0, got1()}, 32'd0);
        checkOutput("hr_halt_w2", {31'd0, halt2}, 32'd1);

        // Saturation on the 2-bit counter, then reset mid-stall.
        step();
        doReset();
        for (int i = 1; i <= 6; i++) begin
            step();
            checkOutput("t6_cnt2", {30'd0, stall_cnt2}, (i > 3) ? 32'd3 : i);
            checkOutput("t6_cnt16", {16'd0, stall_cnt}, i);
        end
        ihit = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_cnt2", {30'd0, stall_cnt2}, 32'd0);
        checkOutput("t6_rst_cnt16", {16'd0, stall_cnt}, 32'd0);
        checkOutput("t6_rst_en", {25'd0, got1()}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("t6_post_en", {25'd0, got1()}, {25'd0, 7'b1111100});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
